// File: rtl/hex_scan_mux_pkg.sv
// Shared display definitions for the hex scan multiplexer: scan FSM states,
// digit count, anode idle pattern and the leading-zero blanking rule.
package hex_scan_mux_pkg;

   typedef enum logic {BLANK, ON} scan_state_t;

   localparam int unsigned NUM_DIGITS = 4;
   localparam logic [3:0]  ANODES_OFF = 4'b1111;

   // Digit d is a leading zero when it and every higher nibble are zero.
   // Digit 0 is always shown.
   function automatic logic lz_blanked(input logic [1:0]  d,
                                       input logic [15:0] v,
                                       input logic        bl);
      return bl && (d != 2'd0) && ((v >> {d, 2'b00}) == 16'h0000);
   endfunction

endpackage

// File: rtl/hex_scan_mux_tick.sv
// Slot prescaler for the hex scan multiplexer: counts 0..DIV-1 and pulses
// tick in the cycle the count equals DIV-1.
module scan_tick_gen #(
   parameter int unsigned DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CW = $clog2(DIV);

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == CW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)       cnt_q <= '0;
      else if (tick) cnt_q <= '0;
      else           cnt_q <= cnt_q + CW'(1);
   end

endmodule

// File: rtl/hex_scan_mux.sv
// Time-multiplexed four-digit hex display driver: latches a 16-bit value,
// scans the digits with a guard gap per slot and optional leading-zero blanking.
module hex_scan_mux
   import hex_scan_mux_pkg::*;
#(
   parameter int unsigned DIV   = 50000,
   parameter int unsigned GUARD = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] value,
   input  logic        blank_lz,
   output logic [3:0]  h,
   output logic [3:0]  an,
   output logic [1:0]  digit
);

   localparam int unsigned GW = $clog2(DIV);

   logic          tick;
   scan_state_t   state_q, state_d;
   logic [GW-1:0] guard_q, guard_d;
   logic [1:0]    digit_q, digit_d;
   logic [15:0]   value_q, value_d;
   logic [3:0]    an_q, an_d;

   scan_tick_gen #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // an is computed from the next-cycle state, digit and value so the
   // registered enables line up with h in the same cycle.
   always_comb begin
      value_d = load ? value : value_q;
      state_d = state_q;
      guard_d = guard_q;
      digit_d = digit_q;
      an_d    = ANODES_OFF;

      if (tick) begin
         state_d = BLANK;
         guard_d = '0;
         digit_d = digit_q + 2'd1;
      end else if (state_q == BLANK) begin
         guard_d = guard_q + GW'(1);
         if (guard_q == GW'(GUARD - 1)) state_d = ON;
      end

      if (state_d == ON && !lz_blanked(digit_d, value_d, blank_lz))
         an_d[digit_d] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
         state_q <= BLANK;
         guard_q <= '0;
         digit_q <= '0;
         an_q    <= ANODES_OFF;
      end else begin
         value_q <= value_d;
         state_q <= state_d;
         guard_q <= guard_d;
         digit_q <= digit_d;
         an_q    <= an_d;
      end
   end

   assign h     = value_q[{digit_q, 2'b00} +: 4];
   assign an    = an_q;
   assign digit = digit_q;

endmodule

// File: tb/tb_hex_scan_mux.sv
// Self-checking bench for hex_scan_mux (DIV=8, GUARD=2): slot-arithmetic model
// checked every cycle, directed literal scenarios, then randomized traffic.
module tb_hex_scan_mux;

   localparam int unsigned DIV   = 8;
   localparam int unsigned GUARD = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = 16'h0000;
   logic        blank_lz = 1'b0;
   logic [3:0]  h, an;
   logic [1:0]  digit;

   int total = 0;
   int bad   = 0;

   hex_scan_mux #(.DIV(DIV), .GUARD(GUARD)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .value    (value),
      .blank_lz (blank_lz),
      .h        (h),
      .an       (an),
      .digit    (digit)
   );

   always #5 clk = ~clk;

   // Model: t = cycles since last reset edge; slot/phase follow from t alone.
   int          mt = 0;
   logic        mvalid = 1'b0;
   logic [15:0] mval = 16'h0000;
   logic        mbl = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         mt     = 0;
         mval   = 16'h0000;
         mvalid = 1'b1;
      end else begin
         mt = mt + 1;
         if (load) mval = value;
      end
      mbl = blank_lz;
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   int          edg, eph;
   logic [3:0]  eh, ean, one;
   logic        eblk;

   always @(negedge clk) begin
      if (mvalid) begin
         edg  = (mt / DIV) % 4;
         eph  = mt % DIV;
         eh   = 4'((mval >> (4 * edg)) & 16'hF);
         eblk = mbl && (edg != 0) && ((mval >> (4 * edg)) == 16'h0000);
         one  = 4'b0001;
         ean  = (eph < GUARD || eblk) ? 4'b1111 : ~(one << edg);
         chk("model_digit", 16'(digit), 16'(edg));
         chk("model_h", 16'(h), 16'(eh));
         chk("model_an", 16'(an), 16'(ean));
         chk("an_single_zero", 16'($countones(~an) <= 1), 16'd1);
      end
   end

   int tt = 0;

   task automatic goto_t(input int k);
      repeat (k - tt) @(negedge clk);
      tt = k;
   endtask

   task automatic restart(input logic [15:0] v, input logic bl);
      @(negedge clk); #1 rst = 1'b1; load = 1'b0;
      @(negedge clk); #1 rst = 1'b0; load = 1'b1; value = v; blank_lz = bl;
      @(negedge clk); #1 load = 1'b0;
      tt = 1;
   endtask

   function automatic logic [15:0] rand_val();
      logic [15:0] v;
      v = 16'($urandom);
      for (int n = 0; n < 4; n++)
         if ($urandom_range(0, 1) == 0) v = v & ~(16'hF << (4 * n));
      return v;
   endfunction

   logic [3:0] sh [4]  = '{4'hF, 4'h2, 4'hA, 4'h1};
   logic [3:0] san [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
   logic [3:0] sbz [4] = '{4'hE, 4'hD, 4'hF, 4'hF};

   initial begin
      // Reset held for three edges, then release.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_an", 16'(an), 16'hF);
      chk("rst_h", 16'(h), 16'h0);
      chk("rst_digit", 16'(digit), 16'h0);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_guard_an", 16'(an), 16'hF);
      @(negedge clk);
      chk("rst_first_on_an", 16'(an), 16'hE);

      // Full scan of 1A2F without blanking.
      restart(16'h1A2F, 1'b0);
      for (int s = 0; s < 4; s++) begin
         goto_t(8 * s + 2);
         chk("scan_h", 16'(h), 16'(sh[s]));
         chk("scan_an_first", 16'(an), 16'(san[s]));
         goto_t(8 * s + 7);
         chk("scan_an_last", 16'(an), 16'(san[s]));
         goto_t(8 * s + 8);
         chk("scan_gap0", 16'(an), 16'hF);
         goto_t(8 * s + 9);
         chk("scan_gap1", 16'(an), 16'hF);
      end

      // Leading-zero blanking.
      restart(16'h0050, 1'b1);
      for (int s = 0; s < 4; s++) begin
         goto_t(8 * s + 4);
         chk("blank_0050_an", 16'(an), 16'(sbz[s]));
      end
      restart(16'h0000, 1'b1);
      for (int s = 0; s < 4; s++) begin
         goto_t(8 * s + 4);
         chk("blank_0000_an", 16'(an), (s == 0) ? 16'hE : 16'hF);
         chk("blank_0000_h", 16'(h), 16'h0);
      end

      // Load coinciding with the digit-1 tick.
      restart(16'h1234, 1'b0);
      goto_t(15);
      #1 load = 1'b1; value = 16'hBEEF;
      goto_t(16);
      chk("coll_digit", 16'(digit), 16'h2);
      chk("coll_h", 16'(h), 16'hE);
      chk("coll_an", 16'(an), 16'hF);
      #1 load = 1'b0;
      goto_t(18);
      chk("coll_an_on", 16'(an), 16'hB);

      // Reset in the middle of digit 3's ON phase.
      restart(16'h1A2F, 1'b0);
      goto_t(30);
      chk("mid_pre_an", 16'(an), 16'h7);
      chk("mid_pre_digit", 16'(digit), 16'h3);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("mid_an", 16'(an), 16'hF);
      chk("mid_digit", 16'(digit), 16'h0);
      chk("mid_h", 16'(h), 16'h0);
      #1 rst = 1'b0;
      tt = 0;
      goto_t(2);
      chk("mid_restart_an", 16'(an), 16'hE);
      chk("mid_restart_digit", 16'(digit), 16'h0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         rst   = ($urandom_range(0, 299) == 0);
         load  = ($urandom_range(0, 7) == 0);
         value = rand_val();
         if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      end
      @(negedge clk);
      #1 rst = 1'b0; load = 1'b0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
